delayed_branch_scheduler: RTL and testbench
===========================================

Name: delayed_branch_scheduler

Overview:
- Holds the delayed-branch halves produced by the branch unit for lanes p0 and p1 in program order.
- When stage 3 retires the owning branch, evaluates the entry's condition against N/V/Z. If the condition is true, it reinjects the stored instruction into the owning lane through the do_delayed_B inputs and flushes all younger entries.
- Sits between the branch unit (producer) and the stage-3 flag logic and fetch (consumers).

Parameters:
- DEPTH, 4, queue entries; power of two, at least 2.
- CNT_W, 16, width of the optional statistics counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- p0_push  in  1  p0 offers a delayed entry this cycle.
- p0_entry  in  16  p0 delayed instruction: head[15:8], destination[7:0].
- p0_cond  in  3  p0 delayed condition code.
- p1_push  in  1  p1 offers a delayed entry this cycle.
- p1_entry  in  16  p1 delayed instruction.
- p1_cond  in  3  p1 delayed condition code.
- res_valid  in  1  stage 3 retires the branch owning the head entry.
- N  in  1  stage-3 negative flag.
- V  in  1  stage-3 overflow flag.
- Z  in  1  stage-3 zero flag.
- inj_ready  in  1  pipeline accepts the reinjected instruction.
- inj_IR  out  16  instruction to reinject.
- p0_do_delayed_B  out  1  reinjection targets p0.
- p1_do_delayed_B  out  1  reinjection targets p1.
- flush  out  1  one-cycle pulse: younger in-flight work is invalid.
- stall_fetch  out  1  fewer than 2 free entries.
- overflow  out  1  sticky: a push was dropped.
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst low, asynchronous):
  - Queue empty; count=0; state IDLE.
  - All outputs 0, including overflow and inj_IR.
- Entry fields: {lane, IR[15:0], cond[2:0]}.
  - Circular buffer; head/tail pointers wrap modulo DEPTH.
- Push:
  - Same-cycle pushes enqueue p0 first, then p1 (program order).
  - A push with no free slot is dropped and sets overflow until reset.
  - stall_fetch = (DEPTH - count) < 2, combinational from registered count.
- Condition evaluation, on the head entry when res_valid=1:
  - NV=0: false. AL=1: true. EQ=2: Z. NE=3: !Z.
  - LT=4: N^V. LE=5: (N^V)|Z. GT=6: !((N^V)|Z). GE=7: !(N^V).
- res_valid with an empty queue: ignored, no state change.
- State machine:
  - IDLE (count=0) -> PENDING on any push.
  - PENDING -> PENDING or IDLE on res_valid with false condition. Pop head; same-cycle pushes still enqueue, after the pop.
  - PENDING -> REDIRECT on res_valid with true condition:
    - Latch inj_IR and lane.
    - Clear the whole queue, including same-cycle pushes (younger, wrong path).
    - Pulse flush for exactly 1 cycle, the cycle after res_valid.
  - REDIRECT: drive inj_IR; p0_do_delayed_B or p1_do_delayed_B high per lane (one-hot, never both). Hold until inj_ready=1.
    - Pushes in REDIRECT are discarded and do not set overflow.
    - res_valid in REDIRECT is ignored.
  - REDIRECT -> IDLE on the cycle after inj_ready. do_delayed_B drops that cycle.
- Latency: res_valid (cycle t) -> do_delayed_B high at t+1. Minimum redirect length 1 cycle.
- inj_IR holds its last value outside REDIRECT; consumers qualify it with do_delayed_B.
- Async reset mid-REDIRECT: do_delayed_B drops immediately; nothing is reinjected.

Optional Feature:
- Macro DBS_STATS_EN.
- Defined: adds outputs taken_cnt and nottaken_cnt, each CNT_W bits.
  - Incremented on each true/false resolve respectively.
  - Saturate at all-ones; cleared by reset.
- Undefined: these ports and their logic do not exist; behaviour is otherwise identical.

Test Plan:
- Reset, then p0_push IR=0x2105 cond=EQ; res_valid with Z=1 -> next cycle p0_do_delayed_B=1, inj_IR=0x2105, flush pulses 1 cycle, count=0.
- p0 and p1 push together (cond NE then LT); res_valid Z=1 (NE false) -> head popped, count=1. Then res_valid N=1, V=0 -> p1_do_delayed_B=1 with the p1 IR.
- DEPTH=4: push 3 entries -> stall_fetch=1 at count=3. Push 2 more -> count=4, overflow=1, one entry dropped.
- Same cycle: res_valid with true condition plus p1_push -> p1 entry discarded; count=0 after the redirect completes.
- Hold inj_ready=0 for 3 cycles -> do_delayed_B and inj_IR stable throughout. inj_ready=1 -> IDLE next cycle.
- Assert rst low while in REDIRECT -> outputs 0 immediately (asynchronous). With DBS_STATS_EN: 3 false + 2 true resolves -> nottaken_cnt=3, taken_cnt=2.

Source files
------------

// File: rtl/delayed_branch_scheduler.sv
// delayed_branch_scheduler
// Program-ordered queue of delayed-branch halves from lanes p0/p1. When the
// owning branch retires, the head entry's condition is checked against N/V/Z:
// false pops the head, true reinjects the stored instruction into its lane,
// flushes every younger entry and holds the redirect until inj_ready.
//
// Optional build macro: DBS_STATS_EN adds saturating taken/not-taken
// resolve counters (taken_cnt, nottaken_cnt).
//
// Handshake: the redirect is offered while p0_do_delayed_B or p1_do_delayed_B
// is high (one-hot, inj_IR valid); it is consumed on the rising edge where
// inj_ready is also high, and do_delayed_B drops in the following cycle.
// inj_ready outside a redirect has no effect.
module delayed_branch_scheduler #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     p0_push,
    input  logic [15:0]              p0_entry,
    input  logic [2:0]               p0_cond,
    input  logic                     p1_push,
    input  logic [15:0]              p1_entry,
    input  logic [2:0]               p1_cond,
    input  logic                     res_valid,
    input  logic                     N,
    input  logic                     V,
    input  logic                     Z,
    input  logic                     inj_ready,
    output logic [15:0]              inj_IR,
    output logic                     p0_do_delayed_B,
    output logic                     p1_do_delayed_B,
    output logic                     flush,
    output logic                     stall_fetch,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   count,
`ifdef DBS_STATS_EN
    output logic [CNT_W-1:0]         taken_cnt,
    output logic [CNT_W-1:0]         nottaken_cnt,
`endif
    output logic [1:0]               dbg_state
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PENDING  = 2'd1,
        REDIRECT = 2'd2
    } state_e;

    state_e          r_state;
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_count;
    logic            r_lane [DEPTH];
    logic [15:0]     r_ir   [DEPTH];
    logic [2:0]      r_cond [DEPTH];
    logic [15:0]     r_inj_ir;
    logic            r_p0_do;
    logic            r_p1_do;
    logic            r_flush;
    logic            r_overflow;

    logic            w_active;
    logic            w_cond_true;
    logic            w_resolve;
    logic            w_taken;
    logic            w_pop;
    logic [CW-1:0]   w_free;
    logic            w_p0_ok;
    logic            w_p1_ok;
    logic            w_drop;
    logic [PW-1:0]   w_wr1_idx;
    logic [CW-1:0]   w_count_nxt;

    function automatic logic cond_true(input logic [2:0] c, input logic n, input logic v,
                                       input logic z);
        logic lt;
        logic r;
        lt = n ^ v;
        r  = 1'b0;
        case (c)
            3'd0: r = 1'b0;          // NV
            3'd1: r = 1'b1;          // AL
            3'd2: r = z;             // EQ
            3'd3: r = ~z;            // NE
            3'd4: r = lt;            // LT
            3'd5: r = lt | z;        // LE
            3'd6: r = ~(lt | z);     // GT
            3'd7: r = ~lt;           // GE
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Resolve decision and push acceptance; pushes see the slot freed by a same-cycle pop
    always_comb begin
        w_active    = (r_state != REDIRECT);
        w_cond_true = cond_true(r_cond[r_head], N, V, Z);
        w_resolve   = w_active && res_valid && (r_count != '0);
        w_taken     = w_resolve && w_cond_true;
        w_pop       = w_resolve && !w_cond_true;
        w_free      = CW'(DEPTH) - r_count + CW'(w_pop);
        w_p0_ok     = w_active && !w_taken && p0_push && (w_free != '0);
        w_p1_ok     = w_active && !w_taken && p1_push &&
                      (w_p0_ok ? (w_free >= CW'(2)) : (w_free != '0));
        w_drop      = w_active && !w_taken &&
                      ((p0_push && !w_p0_ok) || (p1_push && !w_p1_ok));
        w_wr1_idx   = r_tail + PW'(w_p0_ok);
        w_count_nxt = r_count - CW'(w_pop) + CW'(w_p0_ok) + CW'(w_p1_ok);
    end

    // Entry storage: p0 lands at the tail, p1 right behind it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_lane[i] <= 1'b0;
                r_ir[i]   <= '0;
                r_cond[i] <= '0;
            end
        end else begin
            if (w_p0_ok) begin
                r_lane[r_tail] <= 1'b0;
                r_ir[r_tail]   <= p0_entry;
                r_cond[r_tail] <= p0_cond;
            end
            if (w_p1_ok) begin
                r_lane[w_wr1_idx] <= 1'b1;
                r_ir[w_wr1_idx]   <= p1_entry;
                r_cond[w_wr1_idx] <= p1_cond;
            end
        end
    end

    // Control FSM: queue pointers, redirect latch, flush pulse and sticky overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_inj_ir   <= '0;
            r_p0_do    <= 1'b0;
            r_p1_do    <= 1'b0;
            r_flush    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                IDLE, PENDING: begin
                    r_flush <= w_taken;
                    if (w_drop)
                        r_overflow <= 1'b1;
                    if (w_taken) begin
                        // Everything behind the taken head is wrong-path work
                        r_inj_ir <= r_ir[r_head];
                        r_p0_do  <= ~r_lane[r_head];
                        r_p1_do  <= r_lane[r_head];
                        r_head   <= '0;
                        r_tail   <= '0;
                        r_count  <= '0;
                        r_state  <= REDIRECT;
                    end else begin
                        r_head  <= r_head + PW'(w_pop);
                        r_tail  <= r_tail + PW'(w_p0_ok) + PW'(w_p1_ok);
                        r_count <= w_count_nxt;
                        r_state <= (w_count_nxt == '0) ? IDLE : PENDING;
                    end
                end
                REDIRECT: begin
                    r_flush <= 1'b0;
                    if (inj_ready) begin
                        r_p0_do <= 1'b0;
                        r_p1_do <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef DBS_STATS_EN
    // Saturating resolve statistics
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            taken_cnt    <= '0;
            nottaken_cnt <= '0;
        end else begin
            if (w_taken && (taken_cnt != '1))
                taken_cnt <= taken_cnt + 1'b1;
            if (w_pop && (nottaken_cnt != '1))
                nottaken_cnt <= nottaken_cnt + 1'b1;
        end
    end
`endif

    assign inj_IR          = r_inj_ir;
    assign p0_do_delayed_B = r_p0_do;
    assign p1_do_delayed_B = r_p1_do;
    assign flush           = r_flush;
    assign overflow        = r_overflow;
    assign count           = r_count;
    assign stall_fetch     = (CW'(DEPTH) - r_count) < CW'(2);
    assign dbg_state       = r_state;

endmodule

// File: tb/tb_delayed_branch_scheduler.sv
// Testbench for delayed_branch_scheduler: directed scenarios plus a random
// phase, checked cycle by cycle against a queue model, with reinjected
// instructions matched through an expected queue.
module tb_delayed_branch_scheduler;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          p0_push = 1'b0, p1_push = 1'b0;
    logic [15:0]   p0_entry = '0, p1_entry = '0;
    logic [2:0]    p0_cond = '0, p1_cond = '0;
    logic          res_valid = 1'b0, N = 1'b0, V = 1'b0, Z = 1'b0, inj_ready = 1'b0;
    logic [15:0]   inj_IR;
    logic          p0_do_delayed_B, p1_do_delayed_B, flush, stall_fetch, overflow;
    logic [CW-1:0] count;
    logic [1:0]    dbg_state;
`ifdef DBS_STATS_EN
    logic [CNT_W-1:0] taken_cnt, nottaken_cnt;
`endif

    delayed_branch_scheduler #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .p0_push(p0_push), .p0_entry(p0_entry), .p0_cond(p0_cond),
        .p1_push(p1_push), .p1_entry(p1_entry), .p1_cond(p1_cond),
        .res_valid(res_valid), .N(N), .V(V), .Z(Z), .inj_ready(inj_ready),
        .inj_IR(inj_IR), .p0_do_delayed_B(p0_do_delayed_B),
        .p1_do_delayed_B(p1_do_delayed_B), .flush(flush),
        .stall_fetch(stall_fetch), .overflow(overflow), .count(count),
`ifdef DBS_STATS_EN
        .taken_cnt(taken_cnt), .nottaken_cnt(nottaken_cnt),
`endif
        .dbg_state(dbg_state)
    );

    // ---------------- scoreboard / model state ----------------
    int          checks = 0;
    int          failures = 0;
    logic [16:0] exp_q[$];     // {lane, IR} of expected reinjections
    logic [19:0] m_q[$];       // model queue {lane, IR, cond}
    logic        m_redir, m_flush, m_lane, m_ovf;
    logic [15:0] m_ir;
    int          m_taken, m_nottaken;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic ref_cond(input logic [2:0] c, input logic n, input logic v,
                                      input logic z);
        logic lt;
        lt = (n != v);
        case (c)
            3'd0: return 1'b0;
            3'd1: return 1'b1;
            3'd2: return z;
            3'd3: return !z;
            3'd4: return lt;
            3'd5: return lt || z;
            3'd6: return !(lt || z);
            default: return !lt;
        endcase
    endfunction

    task automatic model_clear();
        check("sb_drain", exp_q.size(), 0);
        exp_q.delete();
        m_q.delete();
        m_redir = 1'b0; m_flush = 1'b0; m_lane = 1'b0; m_ovf = 1'b0;
        m_ir = '0; m_taken = 0; m_nottaken = 0;
    endtask

    task automatic check_outputs();
        check("count", count, m_q.size());
        check("stall_fetch", stall_fetch, (DEPTH - m_q.size()) < 2);
        check("overflow", overflow, m_ovf);
        check("flush", flush, m_flush);
        check("p0_do", p0_do_delayed_B, m_redir && !m_lane);
        check("p1_do", p1_do_delayed_B, m_redir && m_lane);
        check("inj_IR", inj_IR, m_ir);
        check("state", dbg_state, m_redir ? 2 : (m_q.size() == 0 ? 0 : 1));
`ifdef DBS_STATS_EN
        check("taken_cnt", taken_cnt, m_taken);
        check("nottaken_cnt", nottaken_cnt, m_nottaken);
`endif
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic a0, input logic [15:0] e0, input logic [2:0] c0,
                         input logic a1, input logic [15:0] e1, input logic [2:0] c1,
                         input logic res, input logic n, input logic v, input logic z,
                         input logic rdy);
        logic [19:0] hd;
        logic [16:0] e;
        p0_push = a0; p0_entry = e0; p0_cond = c0;
        p1_push = a1; p1_entry = e1; p1_cond = c1;
        res_valid = res; N = n; V = v; Z = z; inj_ready = rdy;
        // model the edge
        if (m_redir) begin
            m_flush = 1'b0;
            if (rdy) m_redir = 1'b0;
        end else begin
            m_flush = 1'b0;
            if (res && m_q.size() > 0) begin
                hd = m_q[0];
                if (ref_cond(hd[2:0], n, v, z)) begin
                    m_lane = hd[19]; m_ir = hd[18:3];
                    exp_q.push_back({hd[19], hd[18:3]});
                    m_q.delete();
                    m_redir = 1'b1; m_flush = 1'b1;
                    if (m_taken < 65535) m_taken++;
                end else begin
                    void'(m_q.pop_front());
                    if (m_nottaken < 65535) m_nottaken++;
                end
            end
            if (!m_redir) begin
                if (a0) begin
                    if (m_q.size() < DEPTH) m_q.push_back({1'b0, e0, c0});
                    else m_ovf = 1'b1;
                end
                if (a1) begin
                    if (m_q.size() < DEPTH) m_q.push_back({1'b1, e1, c1});
                    else m_ovf = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        // redirect entry: pop expected reinjection
        if ((p0_do_delayed_B || p1_do_delayed_B) && flush) begin
            if (exp_q.size() == 0) check("sb_unexpected", 1, 0);
            else begin
                e = exp_q.pop_front();
                check("sb_inject", {p1_do_delayed_B, inj_IR}, e);
            end
        end
        check_outputs();
    endtask

    task automatic idle(input logic rdy);
        drive(0, '0, '0, 0, '0, '0, 0, 0, 0, 0, rdy);
    endtask
    task automatic push0(input logic [15:0] e, input logic [2:0] c);
        drive(1, e, c, 0, '0, '0, 0, 0, 0, 0, 0);
    endtask
    task automatic push2(input logic [15:0] e0, input logic [2:0] c0,
                         input logic [15:0] e1, input logic [2:0] c1);
        drive(1, e0, c0, 1, e1, c1, 0, 0, 0, 0, 0);
    endtask
    task automatic resolve(input logic n, input logic v, input logic z);
        drive(0, '0, '0, 0, '0, '0, 1, n, v, z, 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        p0_push = 0; p1_push = 0; res_valid = 0; inj_ready = 0;
        model_clear();
        @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_clear();
        do_reset();

        // Single p0 EQ entry taken on Z=1
        push0(16'h2105, 3'd2);
        resolve(0, 0, 1);
        check("t1_p0_do", p0_do_delayed_B, 1);
        check("t1_inj", inj_IR, 16'h2105);
        check("t1_count", count, 0);
        idle(1);
        check("t1_flush_done", flush, 0);

        // Pair push, NE false pops p0, LT true redirects to p1
        push2(16'h1111, 3'd3, 16'h2222, 3'd4);
        resolve(0, 0, 1);
        check("t2_count", count, 1);
        resolve(1, 0, 0);
        check("t2_p1_do", p1_do_delayed_B, 1);
        check("t2_inj", inj_IR, 16'h2222);
        idle(1);

        // Fill: stall at 3, overflow when a fifth push arrives
        push0(16'h0a01, 3'd1);
        push0(16'h0a02, 3'd0);
        push0(16'h0a03, 3'd0);
        check("t3_stall", stall_fetch, 1);
        push2(16'h0a04, 3'd0, 16'h0a05, 3'd0);
        check("t3_count_full", count, 4);
        check("t3_overflow", overflow, 1);
        resolve(0, 0, 0);
        idle(1);

        // Taken resolve with a same-cycle p1 push discards the push
        do_reset();
        push0(16'h3333, 3'd1);
        drive(0, '0, '0, 1, 16'h4444, 3'd0, 1, 0, 0, 0, 0);
        idle(1);
        check("t4_count", count, 0);
        check("t4_ovf", overflow, 0);

        // Redirect held three cycles without inj_ready
        push0(16'h5555, 3'd6);
        resolve(0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            idle(0);
            check("t5_hold_do", p0_do_delayed_B, 1);
            check("t5_hold_ir", inj_IR, 16'h5555);
        end
        idle(1);
        check("t5_exit_state", dbg_state, 0);

        // 3 not-taken + 2 taken resolves
        do_reset();
        push2(16'h6001, 3'd0, 16'h6002, 3'd3);
        resolve(0, 0, 1);
        resolve(0, 0, 1);
        push0(16'h6003, 3'd7);
        resolve(1, 0, 0);
        push0(16'h6004, 3'd1);
        resolve(0, 0, 0);
        idle(1);
        push0(16'h6005, 3'd2);
        resolve(0, 0, 1);
        idle(1);
`ifdef DBS_STATS_EN
        check("stats_taken", taken_cnt, 2);
        check("stats_nottaken", nottaken_cnt, 3);
`endif

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 99) < 45, 16'($urandom_range(0, 65535)),
                  3'($urandom_range(0, 7)),
                  $urandom_range(0, 99) < 35, 16'($urandom_range(0, 65535)),
                  3'($urandom_range(0, 7)),
                  $urandom_range(0, 99) < 30, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 99) < 60);
        end
        idle(1);
        idle(1);

        // Asynchronous reset in the middle of a redirect
        do_reset();
        push0(16'h7777, 3'd1);
        resolve(0, 0, 0);
        check("t6_in_redirect", p0_do_delayed_B, 1);
        #2;
        rst = 1'b0;
        #1;
        check("t6_async_p0_do", p0_do_delayed_B, 0);
        check("t6_async_p1_do", p1_do_delayed_B, 0);
        check("t6_async_inj", inj_IR, 0);
        check("t6_async_flush", flush, 0);
        check("t6_async_count", count, 0);
        check("t6_async_state", dbg_state, 0);
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(1);

        // ---------------- final report ----------------
        check("sb_final_drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
